// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler: arbiter/serializer
// state encodings, the divider floor and the line-feed byte that closes a line.
package uart_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

  localparam logic [15:0] MinDiv   = 16'd4;
  localparam logic [7:0]  LineFeed = 8'h0A;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < MinDiv) ? MinDiv : div;
  endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serializer: accepts one byte plus a bit period on a valid/ready handshake
// and shifts it out LSB first between a low start bit and a high stop bit.
module uart_tx_ser
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic [15:0] div_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        stop_end_o
);

  ser_state_e  state_q;
  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_q;
  logic        bit_end;

  assign ready_o = (state_q == S_IDLE);
  assign bit_end = (cnt_q == div_q - 16'd1);

  // The final stop cycle is spent back in S_IDLE, so a waiting byte is accepted
  // exactly when the stop bit has lasted div cycles (10*div accept-to-accept).
  assign stop_end_o = (state_q == S_STOP) && (cnt_q == div_q - 16'd2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      div_q   <= MinDiv;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            div_q   <= clamp_div(div_i);
            shift_q <= data_i;
            cnt_q   <= '0;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_o    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_o    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_o    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (stop_end_o) begin
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Line-locked round-robin scheduler: one requester at a time owns the UART until
// it ends a line with LF, hits the line-length cap, or goes quiet for too long.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int MaxLineLen  = 255,
  parameter int LockTimeout = 1024,
  localparam int GrantW     = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [15:0]         div_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic                tx_o,
  output logic [GrantW-1:0]   grant_o,
  output logic                lock_o,
  output logic                busy_o
);

  localparam int IdleW = $clog2(LockTimeout + 1);

  arb_state_e        state_q;
  logic [GrantW-1:0] rr_ptr_q;
  logic [GrantW-1:0] pick;
  logic              found;
  int                cand;
  logic [7:0]        line_cnt_q;
  logic [IdleW-1:0]  idle_cnt_q;
  logic              last_lf_q;
  logic              ser_ready;
  logic              ser_valid;
  logic              ser_stop_end;
  logic              accept;
  logic              holder_valid;
  logic [7:0]        holder_data;
  logic              release_lock;

  assign holder_valid = req_valid_i[grant_o];
  assign holder_data  = req_data_i[{grant_o, 3'b000} +: 8];
  assign ser_valid    = (state_q == LOCKED) && holder_valid;
  assign accept       = ser_valid && ser_ready;

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCKED) req_ready_o[grant_o] = ser_ready;
  end

  // First valid requester at or after the rotation pointer wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NumReq; i++) begin
      cand = (int'(rr_ptr_q) + i) % NumReq;
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = GrantW'(cand);
      end
    end
  end

  always_comb begin
    release_lock = 1'b0;
    if (state_q == LOCKED) begin
      if (ser_stop_end && (last_lf_q || line_cnt_q == 8'(MaxLineLen))) release_lock = 1'b1;
      if (ser_ready && !holder_valid && idle_cnt_q == IdleW'(LockTimeout - 1)) release_lock = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_o    <= '0;
      rr_ptr_q   <= '0;
      lock_o     <= 1'b0;
      line_cnt_q <= '0;
      idle_cnt_q <= '0;
      last_lf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q    <= LOCKED;
            lock_o     <= 1'b1;
            grant_o    <= pick;
            rr_ptr_q   <= (pick == GrantW'(NumReq - 1)) ? '0 : pick + GrantW'(1);
            line_cnt_q <= '0;
            idle_cnt_q <= '0;
            last_lf_q  <= 1'b0;
          end
        end
        LOCKED: begin
          if (release_lock) begin
            state_q    <= IDLE;
            lock_o     <= 1'b0;
            idle_cnt_q <= '0;
          end else if (holder_valid || !ser_ready) begin
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + IdleW'(1);
          end
          if (accept) begin
            line_cnt_q <= line_cnt_q + 8'd1;
            last_lf_q  <= (holder_data == LineFeed);
          end
        end
      endcase
    end
  end

  uart_tx_ser u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (holder_data),
    .div_i      (div_i),
    .valid_i    (ser_valid),
    .ready_o    (ser_ready),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .stop_end_o (ser_stop_end)
  );

endmodule
